// File: rtl/game_pkg.sv
// Shared definitions for the whack-a-mole display back-end: segment codes,
// FSM state encoding and the BCD-digit to 7-segment decoder.
package game_pkg;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CONV_S = 2'd1;
  localparam logic [1:0] ST_CONV_T = 2'd2;
  localparam logic [1:0] ST_UPDATE = 2'd3;

  localparam logic [13:0] SCORE_MAX = 14'd9999;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_iter.sv
// Iterative double-dabble: one input bit per step, MSB first. Load and step
// may coincide, in which case the first shift happens from a cleared register.
module bin2bcd_iter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [13:0] value,
  input  logic [3:0]  nbits,
  input  logic        step,
  output logic [15:0] bcd
);

  logic [13:0] val_q, val_d;
  logic [15:0] bcd_q, bcd_d;
  logic [13:0] aligned;
  logic [15:0] adj;

  always_comb begin
    // Left-justify so the next bit to shift is always val[13]
    aligned = value << (4'd14 - nbits);
    adj     = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_d = bcd_q;
    val_d = val_q;
    if (load && step) begin
      bcd_d = {15'd0, aligned[13]};
      val_d = {aligned[12:0], 1'b0};
    end else if (load) begin
      bcd_d = '0;
      val_d = aligned;
    end else if (step) begin
      bcd_d = {adj[14:0], val_q[13]};
      val_d = {val_q[12:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q <= '0;
      bcd_q <= '0;
    end else begin
      val_q <= val_d;
      bcd_q <= bcd_d;
    end
  end

  assign bcd = bcd_q;

endmodule

// File: rtl/score_timer_display.sv
// Score/timer/speed to eight active-low 7-segment displays. Score and timer
// share one double-dabble engine; display refresh lands 21 edges after capture.
module score_timer_display
  import game_pkg::*;
#(
  parameter int BLINK_DIV  = 25_000_000,
  parameter bit LEAD_BLANK = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] score,
  input  logic [5:0]  timer,
  input  logic [1:0]  speed_level,
  input  logic        game_over,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic [6:0]  hex6,
  output logic [6:0]  hex7,
  output logic        busy
);

  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [13:0] last_score_q, last_score_d;
  logic [5:0]  last_timer_q, last_timer_d;
  logic        force_q, force_d;
  logic        busy_q, busy_d;
  logic [15:0] score_bcd_q, score_bcd_d;
  logic [27:0] score_seg_q, score_seg_d;
  logic [27:0] new_seg;
  logic [6:0]  hex0_q, hex1_q, hex2_q, hex3_q, hex4_q, hex5_q, hex7_q;
  logic [6:0]  hex4_d, hex5_d, hex7_d;
  logic [27:0] score_out_d;
  logic [BW-1:0] blink_cnt_q;
  logic        blink_ph_q;
  logic        upd;

  logic        eng_load, eng_step;
  logic [13:0] eng_value;
  logic [3:0]  eng_nbits;
  logic [15:0] eng_bcd;

  bin2bcd_iter u_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (eng_load),
    .value (eng_value),
    .nbits (eng_nbits),
    .step  (eng_step),
    .bcd   (eng_bcd)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_score_d = last_score_q;
    last_timer_d = last_timer_q;
    force_d      = force_q;
    busy_d       = busy_q;
    score_bcd_d  = score_bcd_q;
    upd          = 1'b0;
    eng_load     = 1'b0;
    eng_step     = 1'b0;
    eng_value    = '0;
    eng_nbits    = 4'd0;
    case (state_q)
      ST_IDLE: begin
        if (force_q || {score, timer} != {last_score_q, last_timer_q}) begin
          last_score_d = score;
          last_timer_d = timer;
          eng_load     = 1'b1;
          eng_value    = (score > SCORE_MAX) ? SCORE_MAX : score;
          eng_nbits    = 4'd14;
          force_d      = 1'b0;
          busy_d       = 1'b1;
          cnt_d        = 4'd0;
          state_d      = ST_CONV_S;
        end
      end
      ST_CONV_S: begin
        eng_step = 1'b1;
        cnt_d    = cnt_q + 4'd1;
        if (cnt_q == 4'd13) begin
          cnt_d   = 4'd0;
          state_d = ST_CONV_T;
        end
      end
      ST_CONV_T: begin
        eng_step = 1'b1;
        // First timer step reloads the engine; grab the finished score first
        if (cnt_q == 4'd0) begin
          eng_load    = 1'b1;
          eng_value   = {8'd0, last_timer_q};
          eng_nbits   = 4'd6;
          score_bcd_d = eng_bcd;
        end
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd5) begin
          cnt_d   = 4'd0;
          state_d = ST_UPDATE;
        end
      end
      default: begin
        upd     = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    logic bl3, bl2, bl1;
    bl3 = LEAD_BLANK && (score_bcd_q[15:12] == 4'd0);
    bl2 = bl3 && (score_bcd_q[11:8] == 4'd0);
    bl1 = bl2 && (score_bcd_q[7:4] == 4'd0);
    new_seg = {bl3 ? SEG_BLANK : seg_decode(score_bcd_q[15:12]),
               bl2 ? SEG_BLANK : seg_decode(score_bcd_q[11:8]),
               bl1 ? SEG_BLANK : seg_decode(score_bcd_q[7:4]),
               seg_decode(score_bcd_q[3:0])};
    score_seg_d = upd ? new_seg : score_seg_q;
    score_out_d = (game_over && blink_ph_q) ? {4{SEG_BLANK}} : score_seg_d;
    hex4_d      = upd ? seg_decode(eng_bcd[3:0]) : hex4_q;
    hex5_d      = upd ? seg_decode(eng_bcd[7:4]) : hex5_q;
    hex7_d      = (speed_level == 2'd3) ? SEG_DASH : seg_decode({2'b00, speed_level} + 4'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      last_score_q <= '0;
      last_timer_q <= '0;
      force_q      <= 1'b1;
      busy_q       <= 1'b0;
      score_bcd_q  <= '0;
      score_seg_q  <= {4{SEG_BLANK}};
      hex0_q       <= SEG_BLANK;
      hex1_q       <= SEG_BLANK;
      hex2_q       <= SEG_BLANK;
      hex3_q       <= SEG_BLANK;
      hex4_q       <= SEG_BLANK;
      hex5_q       <= SEG_BLANK;
      hex7_q       <= SEG_BLANK;
      blink_cnt_q  <= '0;
      blink_ph_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_score_q <= last_score_d;
      last_timer_q <= last_timer_d;
      force_q      <= force_d;
      busy_q       <= busy_d;
      score_bcd_q  <= score_bcd_d;
      score_seg_q  <= score_seg_d;
      hex0_q       <= score_out_d[6:0];
      hex1_q       <= score_out_d[13:7];
      hex2_q       <= score_out_d[20:14];
      hex3_q       <= score_out_d[27:21];
      hex4_q       <= hex4_d;
      hex5_q       <= hex5_d;
      hex7_q       <= hex7_d;
      if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
        blink_cnt_q <= '0;
        blink_ph_q  <= ~blink_ph_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end
  end

  assign hex0 = hex0_q;
  assign hex1 = hex1_q;
  assign hex2 = hex2_q;
  assign hex3 = hex3_q;
  assign hex4 = hex4_q;
  assign hex5 = hex5_q;
  assign hex6 = SEG_BLANK;
  assign hex7 = hex7_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_score_timer_display.sv
// Bench for score_timer_display: two instances (leading blank on/off) share
// inputs; finished conversions are matched against a queue of expected displays.
module tb_score_timer_display;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] score = '0;
  logic [5:0]  timer = '0;
  logic [1:0]  speed_level = '0;
  logic        game_over = 1'b0;
  logic [6:0]  a_hex0, a_hex1, a_hex2, a_hex3, a_hex4, a_hex5, a_hex6, a_hex7;
  logic [6:0]  b_hex0, b_hex1, b_hex2, b_hex3, b_hex4, b_hex5, b_hex6, b_hex7;
  logic        a_busy, b_busy;

  // Expected = {hex5, hex4, a hex3..hex0, b hex3..hex0}
  logic [69:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned edge_n;
  int          busy_len;
  logic        prev_busy;

  typedef struct packed {
    logic [13:0] score;
    logic [5:0]  timer;
    logic [1:0]  speed;
    logic [31:0] s_lead;
    logic [31:0] s_full;
    logic [15:0] t;
    logic [7:0]  sp;
  } vec_t;

  vec_t vecs[9];

  score_timer_display #(.BLINK_DIV(4), .LEAD_BLANK(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .score(score), .timer(timer),
    .speed_level(speed_level), .game_over(game_over),
    .hex0(a_hex0), .hex1(a_hex1), .hex2(a_hex2), .hex3(a_hex3),
    .hex4(a_hex4), .hex5(a_hex5), .hex6(a_hex6), .hex7(a_hex7), .busy(a_busy)
  );

  score_timer_display #(.BLINK_DIV(4), .LEAD_BLANK(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .score(score), .timer(timer),
    .speed_level(speed_level), .game_over(game_over),
    .hex0(b_hex0), .hex1(b_hex1), .hex2(b_hex2), .hex3(b_hex3),
    .hex4(b_hex4), .hex5(b_hex5), .hex6(b_hex6), .hex7(b_hex7), .busy(b_busy)
  );

  // Clock and edge counter (edges since reset release)
  always #10 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  function automatic logic [6:0] seg(input logic [7:0] c);
    case (c)
      8'h30:   return 7'b1000000;
      8'h31:   return 7'b1111001;
      8'h32:   return 7'b0100100;
      8'h33:   return 7'b0110000;
      8'h34:   return 7'b0011001;
      8'h35:   return 7'b0010010;
      8'h36:   return 7'b0000010;
      8'h37:   return 7'b1111000;
      8'h38:   return 7'b0000000;
      8'h39:   return 7'b0010000;
      8'h2d:   return 7'b0111111;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [69:0] exp_of(input logic [31:0] sl, input logic [31:0] sf,
                                         input logic [15:0] t);
    return {seg(t[15:8]), seg(t[7:0]),
            seg(sl[31:24]), seg(sl[23:16]), seg(sl[15:8]), seg(sl[7:0]),
            seg(sf[31:24]), seg(sf[23:16]), seg(sf[15:8]), seg(sf[7:0])};
  endfunction

  function automatic logic [7:0] dch(input int unsigned d);
    return 8'h30 + 8'(d);
  endfunction

  function automatic logic [69:0] model_exp(input int unsigned s_in, input int unsigned t);
    int unsigned s;
    logic [7:0] c3, c2, c1, c0, l3, l2, l1;
    s  = (s_in > 9999) ? 9999 : s_in;
    c3 = dch(s / 1000);
    c2 = dch((s / 100) % 10);
    c1 = dch((s / 10) % 10);
    c0 = dch(s % 10);
    l3 = (c3 == 8'h30) ? 8'h20 : c3;
    l2 = (l3 == 8'h20 && c2 == 8'h30) ? 8'h20 : c2;
    l1 = (l2 == 8'h20 && c1 == 8'h30) ? 8'h20 : c1;
    return exp_of({l3, l2, l1, c0}, {c3, c2, c1, c0}, {dch(t / 10), dch(t % 10)});
  endfunction

  function automatic vec_t mk(input logic [13:0] s, input logic [5:0] t, input logic [1:0] sp,
                              input logic [31:0] sl, input logic [31:0] sf,
                              input logic [15:0] ts, input logic [7:0] spc);
    vec_t v;
    v.score = s; v.timer = t; v.speed = sp;
    v.s_lead = sl; v.s_full = sf; v.t = ts; v.sp = spc;
    return v;
  endfunction

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [69:0] actual();
    return {a_hex5, a_hex4, a_hex3, a_hex2, a_hex1, a_hex0, b_hex3, b_hex2, b_hex1, b_hex0};
  endfunction

  // Scoreboard: a busy fall-edge means a conversion just landed on the displays
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_busy = 1'b0;
      busy_len  = 0;
    end else begin
      if (a_busy) busy_len++;
      if (prev_busy && !a_busy) begin
        check("busy_len", 70'(busy_len), 70'd21);
        if (exp_q.size() == 0) begin
          check("unexpected_update", 70'd1, 70'd0);
        end else begin
          check("display", actual(), exp_q.pop_front());
        end
        busy_len = 0;
      end
      prev_busy = a_busy;
    end
  end

  task automatic wait_done();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      check("timeout_done", 70'(exp_q.size()), 70'd0);
      exp_q.delete();
    end
  endtask

  task automatic wait_busy();
    int i;
    for (i = 0; i < 50 && !a_busy; i++) @(negedge clk);
    if (!a_busy) check("timeout_busy", 70'd0, 70'd1);
  endtask

  task automatic drive(input logic [13:0] s, input logic [5:0] t, input logic [1:0] sp,
                       input logic [69:0] e, input logic [6:0] e_sp);
    @(negedge clk);
    score = s;
    timer = t;
    speed_level = sp;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    check("speed_digit", 70'(a_hex7), 70'(e_sp));
    wait_done();
  endtask

  initial begin
    logic [69:0] e8, e;
    int unsigned rs, rt;
    int unsigned n;

    vecs[0] = mk(14'd1234,  6'd37, 2'd1, "1234", "1234", "37", "2");
    vecs[1] = mk(14'd7,     6'd5,  2'd2, "   7", "0007", "05", "3");
    vecs[2] = mk(14'd12000, 6'd63, 2'd3, "9999", "9999", "63", "-");
    vecs[3] = mk(14'd16383, 6'd0,  2'd0, "9999", "9999", "00", "1");
    vecs[4] = mk(14'd9999,  6'd59, 2'd1, "9999", "9999", "59", "2");
    vecs[5] = mk(14'd10,    6'd1,  2'd2, "  10", "0010", "01", "3");
    vecs[6] = mk(14'd100,   6'd20, 2'd0, " 100", "0100", "20", "1");
    vecs[7] = mk(14'd1000,  6'd9,  2'd3, "1000", "1000", "09", "-");
    vecs[8] = mk(14'd0,     6'd0,  2'd1, "   0", "0000", "00", "2");

    // Reset state
    score = 14'd0; timer = 6'd60; speed_level = 2'd0; game_over = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_hex", 70'({a_hex7, a_hex6, a_hex5, a_hex4, a_hex3, a_hex2, a_hex1, a_hex0}),
          70'({8{7'b1111111}}));
    check("reset_busy", 70'(a_busy), 70'd0);
    exp_q.push_back(exp_of("   0", "0000", "60"));
    rst_n = 1'b1;
    wait_done();
    check("speed_after_reset", 70'(a_hex7), 70'(seg("1")));
    check("hex6_blank", 70'({a_hex6, b_hex6}), 70'({2{7'b1111111}}));

    // Table of fixed vectors
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].score, vecs[i].timer, vecs[i].speed,
            exp_of(vecs[i].s_lead, vecs[i].s_full, vecs[i].t), seg(vecs[i].sp));
    end

    // Random vectors against the arithmetic model
    for (int i = 0; i < 6; i++) begin
      rs = $urandom_range(0, 16383);
      rt = $urandom_range(0, 63);
      if (14'(rs) == score && 6'(rt) == timer) rt = rt ^ 1;
      n = $urandom_range(0, 3);
      drive(14'(rs), 6'(rt), 2'(n), model_exp(rs, rt),
            (n == 3) ? seg("-") : seg(dch(n + 1)));
    end

    // Blink: score digits alternate every 4 edges, timer stays "00"
    e8 = exp_of("   8", "0008", "00");
    drive(14'd8, 6'd0, 2'd0, e8, seg("1"));
    @(negedge clk);
    game_over = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n = edge_n;
      e = ((((n - 1) / 4) % 2) == 1) ? {e8[69:56], {8{7'b1111111}}} : e8;
      check("blink", actual(), e);
    end
    game_over = 1'b0;
    @(negedge clk);
    check("blink_release", actual(), e8);

    // Change mid-conversion: 5 shows first, then 6
    @(negedge clk);
    score = 14'd5; timer = 6'd11;
    exp_q.push_back(model_exp(5, 11));
    wait_busy();
    repeat (4) @(negedge clk);
    score = 14'd6;
    exp_q.push_back(model_exp(6, 11));
    wait_done();

    // Reset mid-conversion; 0/0 matches the cleared capture, so only the
    // post-reset forced conversion can refresh the display
    @(negedge clk);
    score = 14'd0; timer = 6'd0;
    wait_busy();
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("reset_mid_hex", 70'({a_hex7, a_hex6, a_hex5, a_hex4, a_hex3, a_hex2, a_hex1, a_hex0}),
          70'({8{7'b1111111}}));
    check("reset_mid_busy", 70'(a_busy), 70'd0);
    repeat (2) @(negedge clk);
    exp_q.push_back(exp_of("   0", "0000", "00"));
    rst_n = 1'b1;
    wait_done();

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
